ser_stream_tx: RTL and testbench

- Parametrised successor to the lab serializer.
- Accepts parallel words with a per-word bit count and shifts them out one bit per clock.
- Generalised over data width, with per-word bit order (MSB- or LSB-first) and a valid/ready handshake.
- A one-word holding buffer allows back-to-back words with no idle cycle.
- Adds frame-valid/last strobes and a drop indication for rejected short words; sits between a word producer and a single-wire serial sink.

---
 rtl/ser_stream_tx.sv | 154 +++++++++++++++
 tb/tb_ser_stream_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ser_stream_tx.sv
// Parallel-to-serial word transmitter: per-word length and bit order, valid/ready
// input with a one-word holding buffer so consecutive words stream with no gap.
module ser_stream_tx #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = 5,
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              lsb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              drop_o,
  output logic              busy_o
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [MOD_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              lsb_q, lsb_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_lsb_q, hold_lsb_d;
  logic [MOD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_val_q, ser_val_d;
  logic              ser_last_q, ser_last_d;
  logic              drop_q, drop_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic [MOD_W-1:0]  len;
  logic              accept, short_w, take, last_now;

  function automatic logic [MOD_W-1:0] eff_len(input logic [MOD_W-1:0] m);
    if (m == '0 || m > MOD_W'(DATA_W)) return MOD_W'(DATA_W);
    return m;
  endfunction

  // MSB-first words are pre-shifted so bit L-1 sits at the top; the shifter
  // then only ever reads one fixed end of the register.
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] d,
                                              input logic [MOD_W-1:0]  l,
                                              input logic              lsb);
    if (lsb) return d;
    return d << (MOD_W'(DATA_W) - l);
  endfunction

  always_comb begin
    len      = eff_len(data_mod_i);
    accept   = data_val_i && rdy_q;
    short_w  = len < MOD_W'(MIN_LEN);
    take     = accept && !short_w;
    last_now = (state_q == SHIFT) && (cnt_q == '0);

    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    lsb_d       = lsb_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_lsb_d  = hold_lsb_q;
    hold_cnt_d  = hold_cnt_q;
    drop_d      = accept && short_w;

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = SHIFT;
          sh_d    = align(data_i, len, lsb_first_i);
          lsb_d   = lsb_first_i;
          cnt_d   = len - MOD_W'(1);
        end
      end
      SHIFT: begin
        if (!last_now) begin
          cnt_d = cnt_q - MOD_W'(1);
          sh_d  = lsb_q ? (sh_q >> 1) : (sh_q << 1);
          // Mid-word arrivals park in the hold; rdy guarantees it is empty here.
          if (take) begin
            hold_full_d = 1'b1;
            hold_data_d = align(data_i, len, lsb_first_i);
            hold_lsb_d  = lsb_first_i;
            hold_cnt_d  = len - MOD_W'(1);
          end
        end else if (hold_full_q) begin
          sh_d        = hold_data_q;
          lsb_d       = hold_lsb_q;
          cnt_d       = hold_cnt_q;
          hold_full_d = 1'b0;
        end else if (take) begin
          sh_d  = align(data_i, len, lsb_first_i);
          lsb_d = lsb_first_i;
          cnt_d = len - MOD_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ser_val_d  = (state_d == SHIFT);
    ser_data_d = ser_val_d && (lsb_d ? sh_d[0] : sh_d[DATA_W-1]);
    ser_last_d = ser_val_d && (cnt_d == '0);
    rdy_d      = !hold_full_d;
    busy_d     = ser_val_d || hold_full_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_val_q   <= 1'b0;
      ser_last_q  <= 1'b0;
      drop_q      <= 1'b0;
      rdy_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      ser_data_q  <= ser_data_d;
      ser_val_q   <= ser_val_d;
      ser_last_q  <= ser_last_d;
      drop_q      <= drop_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q       <= cnt_d;
    sh_q        <= sh_d;
    lsb_q       <= lsb_d;
    hold_data_q <= hold_data_d;
    hold_lsb_q  <= hold_lsb_d;
    hold_cnt_q  <= hold_cnt_d;
  end

  assign data_rdy_o     = rdy_q;
  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign ser_last_o     = ser_last_q;
  assign drop_o         = drop_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_ser_stream_tx.sv
// Bench for ser_stream_tx: queue-of-bits reference model compared every cycle,
// directed scenarios with literal expectations, then a randomised stream.
module tb_ser_stream_tx;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 5;
  localparam int MIN_LEN = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic [MOD_W-1:0]  mod = '0;
  logic              lsb = 1'b0;
  logic              val = 1'b0;
  logic              data_rdy, ser_data, ser_val, ser_last, drop, busy;

  ser_stream_tx #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(MIN_LEN)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .data_mod_i(mod),
    .lsb_first_i(lsb), .data_val_i(val), .data_rdy_o(data_rdy),
    .ser_data_o(ser_data), .ser_data_val_o(ser_val), .ser_last_o(ser_last),
    .drop_o(drop), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic last; } sbit_t;
  sbit_t q[$];
  sbit_t got[$];
  logic  drop_exp = 1'b0;
  int    checks = 0;
  int    errors = 0;

  function automatic int eff_len(input logic [MOD_W-1:0] m);
    if (m == 0 || int'(m) > DATA_W) return DATA_W;
    return int'(m);
  endfunction

  function automatic int words_queued();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare at the negedge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic [MOD_W-1:0] m, input logic l);
    logic acc;
    int   len, idx;
    val = v; data = d; mod = m; lsb = l;
    acc = v && (words_queued() < 2);
    @(posedge clk);
    if (rst) begin
      q.delete();
      drop_exp = 1'b0;
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      drop_exp = 1'b0;
      if (acc) begin
        len = eff_len(m);
        if (len < MIN_LEN) drop_exp = 1'b1;
        else for (int i = 0; i < len; i++) begin
          idx = l ? i : len - 1 - i;
          q.push_back('{b: d[idx], last: (i == len - 1)});
        end
      end
    end
    @(negedge clk);
    chk("ser_data_val", 32'(ser_val),  32'(q.size() > 0));
    chk("ser_data",     32'(ser_data), 32'((q.size() > 0) ? q[0].b : 1'b0));
    chk("ser_last",     32'(ser_last), 32'((q.size() > 0) ? q[0].last : 1'b0));
    chk("data_rdy",     32'(data_rdy), 32'(words_queued() < 2));
    chk("busy",         32'(busy),     32'(words_queued() >= 1));
    chk("drop",         32'(drop),     32'(drop_exp));
    if (ser_val) got.push_back('{b: ser_data, last: ser_last});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] got_bits();
    logic [31:0] v = '0;
    foreach (got[i]) v = {v[30:0], got[i].b};
    return v;
  endfunction

  function automatic logic [31:0] got_lasts();
    logic [31:0] v = '0;
    foreach (got[i]) v = {v[30:0], got[i].last};
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("reset_rdy",  32'(data_rdy), 32'd1);
    chk("reset_val",  32'(ser_val),  32'd0);
    chk("reset_busy", 32'(busy),     32'd0);

    // MSB-first 8 of 0xA5C3
    got.delete();
    step(1'b1, 16'hA5C3, 5'd8, 1'b0);
    idle(9);
    chk("t1_count", got.size(), 32'd8);
    chk("t1_bits",  got_bits(), 32'hC3);
    chk("t1_last",  got_lasts(), 32'h01);
    chk("t1_end",   32'(ser_val), 32'd0);

    // back-to-back: second word held, no gap
    got.delete();
    step(1'b1, 16'h000F, 5'd4, 1'b1);
    step(1'b1, 16'h0005, 5'd3, 1'b0);
    chk("t2_rdy_low", 32'(data_rdy), 32'd0);
    idle(8);
    chk("t2_count", got.size(), 32'd7);
    chk("t2_bits",  got_bits(), 32'h7D);
    chk("t2_last",  got_lasts(), 32'h09);

    // length 0 and clamped length
    got.delete();
    step(1'b1, 16'h8001, 5'd0, 1'b0);
    idle(17);
    chk("t3a_count", got.size(), 32'd16);
    chk("t3a_bits",  got_bits(), 32'h8001);
    got.delete();
    step(1'b1, 16'hFFFF, 5'd31, 1'b0);
    idle(17);
    chk("t3b_count", got.size(), 32'd16);
    chk("t3b_bits",  got_bits(), 32'hFFFF);

    // short word dropped
    got.delete();
    step(1'b1, 16'hFFFF, 5'd2, 1'b0);
    chk("t4_drop", 32'(drop),     32'd1);
    chk("t4_val",  32'(ser_val),  32'd0);
    chk("t4_rdy",  32'(data_rdy), 32'd1);
    idle(1);
    chk("t4_drop_end", 32'(drop), 32'd0);
    chk("t4_none", got.size(), 32'd0);

    // reset on bit 5 of a 12-bit word with a word held
    step(1'b1, 16'h0ABC, 5'd12, 1'b0);
    step(1'b1, 16'h1234, 5'd5, 1'b0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_val",  32'(ser_val),  32'd0);
    chk("t5_busy", 32'(busy),     32'd0);
    chk("t5_rdy",  32'(data_rdy), 32'd1);
    got.delete();
    idle(20);
    chk("t5_none", got.size(), 32'd0);

    // randomised stream (~10 us)
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 3) != 0), DATA_W'($urandom),
           MOD_W'($urandom_range(0, 31)), 1'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
